// File: rtl/vedic_mult8_seq_ctrl.sv
// Sequential 8x8 unsigned Vedic multiplier controller: four exact 4x4 nibble
// products, then three additions on a shared external 8-bit adder.
module vedic_mult8_seq_ctrl #(
    parameter bit ZERO_BYPASS = 1'b1,
    parameter int PP_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   a,
    input  logic [PP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*PP_W-1:0] product,
    output logic [PP_W-1:0]   add_a,
    output logic [PP_W-1:0]   add_b,
    output logic              add_cin,
    input  logic [PP_W-1:0]   add_sum,
    input  logic              add_cout
);

    typedef enum logic [2:0] {IDLE, S_MID, S_LOW, S_HIGH, DONE} state_t;

    state_t          state, state_next;
    logic [PP_W-1:0] p0, p1, p2, p3;
    logic [PP_W:0]   x, y;
    logic            zero_op;

    assign zero_op   = ZERO_BYPASS && ((a == '0) || (b == '0));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign add_cin   = 1'b0;

    always_comb begin
        state_next = state;
        add_a      = '0;
        add_b      = '0;
        case (state)
            IDLE: begin
                if (in_valid) state_next = zero_op ? DONE : S_MID;
            end
            S_MID: begin
                add_a      = p1;
                add_b      = p2;
                state_next = S_LOW;
            end
            S_LOW: begin
                add_a      = x[PP_W-1:0];
                add_b      = {4'b0, p0[7:4]};
                state_next = S_HIGH;
            end
            S_HIGH: begin
                add_a      = p3;
                add_b      = {3'b0, y[8:4]};
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Adder results are taken verbatim; the middle-column carry is OR-merged
    // rather than added, and the final carry-out is deliberately dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            p0      <= '0;
            p1      <= '0;
            p2      <= '0;
            p3      <= '0;
            x       <= '0;
            y       <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p0 <= PP_W'(a[3:0]) * PP_W'(b[3:0]);
                        p1 <= PP_W'(a[7:4]) * PP_W'(b[3:0]);
                        p2 <= PP_W'(a[3:0]) * PP_W'(b[7:4]);
                        p3 <= PP_W'(a[7:4]) * PP_W'(b[7:4]);
                        if (zero_op) product <= '0;
                    end
                end
                S_MID:   x <= {add_cout, add_sum};
                S_LOW:   y <= {x[PP_W] | add_cout, add_sum};
                S_HIGH:  product <= {add_sum, y[3:0], p0[3:0]};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult8_seq_ctrl.sv
// Scoreboard bench for vedic_mult8_seq_ctrl with an adder model that can inject
// faults; expected products are derived from plain multiplication or constants.
module tb_vedic_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b, add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic [15:0] product;

    int          n_pass = 0;
    int          n_total = 0;
    int          fault = 0;
    int          phase = 0;
    logic [15:0] sb[$];

    vedic_mult8_seq_ctrl #(.ZERO_BYPASS(1'b1), .PP_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    // Cycles since acceptance: 1, 2, 3 are the three adder steps.
    always @(posedge clk) begin
        if (rst) phase <= 0;
        else if (in_valid && in_ready) phase <= 1;
        else if (phase != 0 && phase < 4) phase <= phase + 1;
        else phase <= 0;
    end

    // Shared adder: exact, optionally with a flipped sum bit in the first
    // addition or a stuck carry-out in the last.
    always_comb begin
        logic [8:0] s9;
        s9 = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
        if (fault == 1 && phase == 1) s9[0] = ~s9[0];
        if (fault == 2 && phase == 3) s9[8] = 1'b1;
        add_sum  = s9[7:0];
        add_cout = s9[8];
    end

    function automatic logic [15:0] ref_prod(input logic [7:0] av, input logic [7:0] bv);
        return 16'(av) * 16'(bv);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every product handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got product 0x%0h, expected no output at %0t", product, $time);
            end else begin
                check("product", product, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        sb.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int w = 0;
        while (sb.size() != 0 && w < 60) begin
            tick();
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            w++;
        end
        out_ready = 1'b1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 0xFF * 0xFF: adder operand sequence and latency
        send(8'hFF, 8'hFF, 16'hFE01);
        @(negedge clk);
        check("c1_add_a", add_a, 8'hE1);
        check("c1_add_b", add_b, 8'hE1);
        check("c1_in_ready", in_ready, 0);
        @(negedge clk);
        check("c2_add_a", add_a, 8'hC2);
        check("c2_add_b", add_b, 8'h0E);
        @(negedge clk);
        check("c3_add_a", add_a, 8'hE1);
        check("c3_add_b", add_b, 8'h1D);
        check("c3_out_valid", out_valid, 0);
        @(negedge clk);
        check("c4_out_valid", out_valid, 1);
        check("c4_product", product, 16'hFE01);
        check("c4_add_a", add_a, 0);
        drain(1'b0);

        // 0x12 * 0x34 with out_ready held high
        send(8'h12, 8'h34, 16'h03A8);
        repeat (4) @(negedge clk);
        check("t2_out_valid", out_valid, 1);
        check("t2_product", product, 16'h03A8);
        @(negedge clk);
        check("t2_c5_out_valid", out_valid, 0);
        check("t2_c5_in_ready", in_ready, 1);
        drain(1'b0);

        // Zero bypass
        send(8'h00, 8'h7F, 16'h0000);
        @(negedge clk);
        check("byp_out_valid", out_valid, 1);
        check("byp_product", product, 0);
        check("byp_add_a", add_a, 0);
        check("byp_add_b", add_b, 0);
        @(negedge clk);
        check("byp_c2_out_valid", out_valid, 0);
        check("byp_c2_add_a", add_a, 0);
        drain(1'b0);

        // Backpressure with ignored operand pulses
        out_ready = 1'b0;
        send(8'h10, 8'h10, 16'h0100);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_product", product, 16'h0100);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            in_valid = (i != 1);
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom_range(1, 255));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", out_valid, 1);
        @(negedge clk);
        check("bp_after_valid", out_valid, 0);
        check("bp_after_product", product, 16'h0100);
        drain(1'b0);

        // Faulty adder: flipped sum bit in the first addition propagates
        fault = 1;
        send(8'hFF, 8'hFF, 16'hFE11);
        drain(1'b0);
        // Forced carry-out in the last addition is ignored
        fault = 2;
        send(8'hFF, 8'hFF, 16'hFE01);
        drain(1'b0);
        fault = 0;

        // Reset during the second addition discards the operation
        send(8'hAB, 8'hCD, ref_prod(8'hAB, 8'hCD));
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_product", product, 0);
        repeat (5) @(negedge clk);
        check("rst_mid_no_output", out_valid, 0);
        send(8'h03, 8'h05, 16'h000F);
        drain(1'b0);

        // Randomized operands with random output backpressure
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            send(ra, rb, ref_prod(ra, rb));
            drain(1'b1);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
